// File: rtl/ltc2308_scan_ctrl_if.sv
// Scan-request and ADC pin bundle between the LTC2308 sequencer and its host side.
// Latency: none, wires only.
// Backpressure: none; start is a fire-and-forget pulse and results are strobes with no ready.
//
// Signals:
//   start/ch_mask/uni    scan request with channel mask and polarity select (host -> sequencer)
//   adc_convst/sck/sdi   LTC2308 control pins (sequencer -> ADC)
//   adc_sdo              LTC2308 serial result (ADC -> sequencer)
//   busy/result_*/scan_done/overrun   status and result strobes (sequencer -> host)
interface ltc2308_scan_ctrl_if;
    logic        start;
    logic [7:0]  ch_mask;
    logic        uni;
    logic        adc_convst;
    logic        adc_sck;
    logic        adc_sdi;
    logic        adc_sdo;
    logic        busy;
    logic        result_valid;
    logic [2:0]  result_ch;
    logic [11:0] result_data;
    logic        scan_done;
    logic        overrun;

    // Sequencer side.
    modport slave (
        input  start, ch_mask, uni, adc_sdo,
        output adc_convst, adc_sck, adc_sdi,
        output busy, result_valid, result_ch, result_data, scan_done, overrun
    );

    // Host plus ADC side.
    modport master (
        output start, ch_mask, uni, adc_sdo,
        input  adc_convst, adc_sck, adc_sdi,
        input  busy, result_valid, result_ch, result_data, scan_done, overrun
    );
endinterface

// File: rtl/ltc2308_scan_ctrl.sv
// Scans the enabled LTC2308 channels in ascending order per start pulse, one {ch, result} strobe each.
// Latency: N+1 frames of CONV_CYCLES + 24*CLK_DIV + 1 cycles; the first frame only primes the config pipeline.
// Backpressure: none; start while busy is dropped and flagged on overrun, results are single-cycle strobes.
//
// Ports:
//   clk_clk      system clock, rising edge
//   reset_reset  asynchronous active-high reset; aborts any frame without emitting a result
//   bus          slave modport of ltc2308_scan_ctrl_if (request, ADC pins, result/status)
module ltc2308_scan_ctrl #(
    parameter int CLK_DIV     = 2,
    parameter int CONV_CYCLES = 80
) (
    input  logic              clk_clk,
    input  logic              reset_reset,
    ltc2308_scan_ctrl_if.slave bus
);
    localparam int            CNT_MAX   = (CONV_CYCLES > CLK_DIV) ? CONV_CYCLES : CLK_DIV;
    localparam int            CW        = $clog2(CNT_MAX + 1);
    localparam logic [CW-1:0] CONV_LAST = CW'(CONV_CYCLES - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(CLK_DIV - 1);

    typedef enum logic [1:0] {IDLE, CONV, SHIFT, NEXT} state_t;
    state_t state, state_nxt;

    logic [CW-1:0] cnt;
    logic [3:0]    bit_cnt;
    logic [7:0]    mask;
    logic          uni_q;
    logic [2:0]    cfg_ch;     // channel whose config word is shifted out this frame
    logic [2:0]    data_ch;    // channel whose conversion is shifted in this frame
    logic          priming;
    logic [5:0]    cfg_sh;
    logic [11:0]   res_sh;
    logic          convst_q, sck_q, sdi_q, busy_q, valid_q, done_q, overrun_q;
    logic [2:0]    res_ch_q;
    logic [11:0]   res_data_q;

    // Next enabled channel strictly after cur, wrapping; returns cur itself if it is the only one.
    function automatic logic [2:0] next_enabled(input logic [7:0] m, input logic [2:0] cur);
        logic [2:0] r;
        logic [2:0] idx;
        logic       found;
        r     = cur;
        found = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            idx = cur + 3'(i);
            if (!found && m[idx]) begin
                r     = idx;
                found = 1'b1;
            end
        end
        return r;
    endfunction

    logic       accept, half_done, last_fall, last_frame;
    logic [2:0] first_ch;
    logic [5:0] cfg_word;

    always_comb begin
        first_ch   = next_enabled(mask, 3'd7);
        cfg_word   = {1'b1, cfg_ch[0], cfg_ch[2], cfg_ch[1], uni_q, 1'b0};
        accept     = (state == IDLE) && !busy_q && bus.start && (bus.ch_mask != 8'd0);
        half_done  = (cnt == HALF_LAST);
        last_fall  = half_done && sck_q && (bit_cnt == 4'd11);
        // The frame that re-sends the first channel's config closes the scan.
        last_frame = !priming && (cfg_ch == first_ch);
        state_nxt  = state;
        case (state)
            IDLE:    if (accept) state_nxt = CONV;
            CONV:    if (cnt == CONV_LAST) state_nxt = SHIFT;
            SHIFT:   if (last_fall) state_nxt = NEXT;
            NEXT:    state_nxt = last_frame ? IDLE : CONV;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) state <= IDLE;
        else             state <= state_nxt;
    end

    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
            cnt        <= '0;
            bit_cnt    <= '0;
            mask       <= '0;
            uni_q      <= 1'b0;
            cfg_ch     <= '0;
            data_ch    <= '0;
            priming    <= 1'b0;
            cfg_sh     <= '0;
            res_sh     <= '0;
            convst_q   <= 1'b0;
            sck_q      <= 1'b0;
            sdi_q      <= 1'b0;
            busy_q     <= 1'b0;
            valid_q    <= 1'b0;
            done_q     <= 1'b0;
            overrun_q  <= 1'b0;
            res_ch_q   <= '0;
            res_data_q <= '0;
        end else begin
            valid_q   <= 1'b0;
            done_q    <= 1'b0;
            overrun_q <= bus.start && busy_q;
            case (state)
                IDLE: begin
                    // busy stays up through the scan_done cycle.
                    if (done_q) busy_q <= 1'b0;
                    if (accept) begin
                        mask     <= bus.ch_mask;
                        uni_q    <= bus.uni;
                        busy_q   <= 1'b1;
                        priming  <= 1'b1;
                        cfg_ch   <= next_enabled(bus.ch_mask, 3'd7);
                        cnt      <= '0;
                        convst_q <= 1'b1;
                    end
                end
                CONV: begin
                    cnt <= cnt + CW'(1);
                    if (cnt == CW'(1)) convst_q <= 1'b0;
                    if (cnt == CONV_LAST) begin
                        cnt     <= '0;
                        bit_cnt <= '0;
                        sck_q   <= 1'b0;
                        cfg_sh  <= cfg_word;
                        sdi_q   <= cfg_word[5];
                    end
                end
                SHIFT: begin
                    if (!half_done) begin
                        cnt <= cnt + CW'(1);
                    end else begin
                        cnt <= '0;
                        if (!sck_q) begin
                            sck_q  <= 1'b1;
                            res_sh <= {res_sh[10:0], bus.adc_sdo};
                        end else begin
                            sck_q   <= 1'b0;
                            cfg_sh  <= {cfg_sh[4:0], 1'b0};
                            sdi_q   <= cfg_sh[4];
                            bit_cnt <= bit_cnt + 4'd1;
                            if (bit_cnt == 4'd11) begin
                                sdi_q <= 1'b0;
                                if (!priming) begin
                                    valid_q    <= 1'b1;
                                    res_ch_q   <= data_ch;
                                    res_data_q <= res_sh;
                                end
                            end
                        end
                    end
                end
                NEXT: begin
                    priming <= 1'b0;
                    data_ch <= cfg_ch;
                    cfg_ch  <= next_enabled(mask, cfg_ch);
                    if (last_frame) begin
                        done_q <= 1'b1;
                    end else begin
                        cnt      <= '0;
                        convst_q <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.adc_convst   = convst_q;
    assign bus.adc_sck      = sck_q;
    assign bus.adc_sdi      = sdi_q;
    assign bus.busy         = busy_q;
    assign bus.result_valid = valid_q;
    assign bus.result_ch    = res_ch_q;
    assign bus.result_data  = res_data_q;
    assign bus.scan_done    = done_q;
    assign bus.overrun      = overrun_q;
endmodule

// File: tb/tb_ltc2308_scan_ctrl.sv
// Bench for ltc2308_scan_ctrl: behavioural LTC2308 model plus SDI/result scoreboards and pin timing checks.
// Latency: n/a.
// Backpressure: n/a.
module tb_ltc2308_scan_ctrl;
    logic clk_clk;
    logic reset_reset;

    ltc2308_scan_ctrl_if bus();

    ltc2308_scan_ctrl #(.CLK_DIV(2), .CONV_CYCLES(80)) dut (
        .clk_clk     (clk_clk),
        .reset_reset (reset_reset),
        .bus         (bus)
    );

    initial clk_clk = 1'b0;
    always #10 clk_clk = ~clk_clk;

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    logic [21:0] outs;
    assign outs = {bus.adc_convst, bus.adc_sck, bus.adc_sdi, bus.busy, bus.result_valid,
                   bus.result_ch, bus.result_data, bus.scan_done, bus.overrun};

    // Scoreboards: 12 SDI bits per frame ({config, 6 zeros}) and {ch, data} per result.
    logic [11:0] exp_sdi[$];
    logic [14:0] exp_res[$];
    logic [11:0] val[8];

    // Monitor / ADC model state.
    int          cyc = 0, t_convst = 0, t_rise = 0, t_rv = 0, t_sd = 0;
    int          nrise = 0, n_convst = 0, nfull = 0, n_sck = 0;
    int          busy_cnt = 0, rv_cnt = 0, sd_cnt = 0, ov_cnt = 0;
    int          bitidx = 0;
    logic        in_scan = 1'b0, convst_p = 1'b0, sck_p = 1'b0;
    logic        cfg_ok = 1'b0;
    logic [2:0]  cfg_ch_m = 3'd0;
    logic [11:0] conv_word = 12'h0, sdi_sh = 12'h0;
    logic [11:0] e_sdi;
    logic [14:0] e_res;

    always @(negedge clk_clk) begin
        cyc++;
        if (reset_reset) begin
            in_scan     = 1'b0;
            nrise       = 0;
            bus.adc_sdo = 1'b0;
        end else begin
            if (bus.busy) busy_cnt++;
            if (bus.adc_convst && !convst_p) begin
                if (in_scan) check("convst_period", cyc - t_convst, 129);
                in_scan  = 1'b1;
                t_convst = cyc;
                nrise    = 0;
                n_convst++;
                // Conversion uses the config captured in the previous frame.
                conv_word   = cfg_ok ? val[cfg_ch_m] : 12'h5A5;
                bitidx      = 0;
                bus.adc_sdo = conv_word[11];
            end
            if (!bus.adc_convst && convst_p) check("convst_width", cyc - t_convst, 2);
            if (bus.adc_sck && !sck_p) begin
                nrise++;
                n_sck++;
                if (nrise == 1) check("sck_first_rise", cyc - t_convst, 82);
                else            check("sck_period", cyc - t_rise, 4);
                t_rise = cyc;
                sdi_sh = {sdi_sh[10:0], bus.adc_sdi};
                if (nrise == 12) begin
                    nfull++;
                    cfg_ch_m = {sdi_sh[9], sdi_sh[8], sdi_sh[10]};
                    cfg_ok   = 1'b1;
                    if (exp_sdi.size() == 0) begin
                        check("sdi_extra_frame", exp_sdi.size(), 1);
                    end else begin
                        e_sdi = exp_sdi.pop_front();
                        check("sdi_word", sdi_sh, e_sdi);
                    end
                end
            end
            if (!bus.adc_sck && sck_p) begin
                bitidx++;
                bus.adc_sdo = (bitidx < 12) ? conv_word[11 - bitidx] : 1'b0;
            end
            if (bus.result_valid) begin
                rv_cnt++;
                t_rv = cyc;
                if (exp_res.size() == 0) begin
                    check("res_extra", exp_res.size(), 1);
                end else begin
                    e_res = exp_res.pop_front();
                    check("res_ch", bus.result_ch, e_res[14:12]);
                    check("res_data", bus.result_data, e_res[11:0]);
                end
            end
            if (bus.scan_done) begin
                sd_cnt++;
                t_sd    = cyc;
                in_scan = 1'b0;
            end
            if (bus.overrun) ov_cnt++;
        end
        convst_p = bus.adc_convst;
        sck_p    = bus.adc_sck;
    end

    initial begin
        repeat (60000) @(posedge clk_clk);
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(negedge clk_clk);
        #1;
    endtask

    task automatic pulse_start();
        tick();
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
    endtask

    task automatic wait_done(input int bound);
        int base;
        base = sd_cnt;
        for (int i = 0; i < bound && sd_cnt == base; i++) tick();
        check("scan_done_seen", sd_cnt - base, 1);
        repeat (3) tick();
    endtask

    int rv0, ov0, sd0;

    initial begin
        reset_reset = 1'b1;
        bus.start   = 1'b0;
        bus.ch_mask = 8'h00;
        bus.uni     = 1'b0;
        for (int i = 0; i < 8; i++) val[i] = 12'h000;
        repeat (3) tick();
        check("reset_outputs", outs, 0);
        reset_reset = 1'b0;
        repeat (2) tick();
        check("idle_outputs", outs, 0);

        // Single channel, unipolar.
        val[0] = 12'hABC;
        bus.ch_mask = 8'h01;
        bus.uni     = 1'b1;
        exp_sdi.push_back({6'b100010, 6'b0});
        exp_sdi.push_back({6'b100010, 6'b0});
        exp_res.push_back({3'd0, 12'hABC});
        n_convst = 0; nfull = 0; busy_cnt = 0; rv0 = rv_cnt;
        pulse_start();
        check("t1_busy_after_start", bus.busy, 1);
        wait_done(1000);
        check("t1_frames", n_convst, 2);
        check("t1_full_frames", nfull, 2);
        check("t1_busy_width", busy_cnt, 259);
        check("t1_results", rv_cnt - rv0, 1);
        check("t1_done_after_result", t_sd - t_rv, 1);
        check("t1_res_queue", exp_res.size(), 0);
        check("t1_sdi_queue", exp_sdi.size(), 0);
        check("t1_hold_ch", bus.result_ch, 0);
        check("t1_hold_data", bus.result_data, 12'hABC);
        check("t1_busy_low", bus.busy, 0);

        // Two channels, CH0 and CH7.
        val[0] = 12'h123;
        val[7] = 12'hFED;
        bus.ch_mask = 8'h81;
        exp_sdi.push_back({6'b100010, 6'b0});
        exp_sdi.push_back({6'b111110, 6'b0});
        exp_sdi.push_back({6'b100010, 6'b0});
        exp_res.push_back({3'd0, 12'h123});
        exp_res.push_back({3'd7, 12'hFED});
        n_convst = 0; rv0 = rv_cnt;
        pulse_start();
        wait_done(1500);
        check("t2_frames", n_convst, 3);
        check("t2_results", rv_cnt - rv0, 2);
        check("t2_res_queue", exp_res.size(), 0);
        check("t2_sdi_queue", exp_sdi.size(), 0);

        // Empty mask is ignored.
        bus.ch_mask = 8'h00;
        n_convst = 0; busy_cnt = 0; rv0 = rv_cnt; ov0 = ov_cnt;
        n_sck = 0; sd0 = sd_cnt;
        pulse_start();
        check("t3_busy", bus.busy, 0);
        repeat (200) tick();
        check("t3_convst", n_convst, 0);
        check("t3_sck", n_sck, 0);
        check("t3_busy_cycles", busy_cnt, 0);
        check("t3_results", rv_cnt - rv0, 0);
        check("t3_done", sd_cnt - sd0, 0);
        check("t3_overrun", ov_cnt - ov0, 0);

        // Bipolar CH1+CH2, with a repeated start and mask/uni changes mid-scan.
        val[1] = 12'h2A5;
        val[2] = 12'h5C3;
        bus.ch_mask = 8'h06;
        bus.uni     = 1'b0;
        exp_sdi.push_back({6'b110000, 6'b0});
        exp_sdi.push_back({6'b100100, 6'b0});
        exp_sdi.push_back({6'b110000, 6'b0});
        exp_res.push_back({3'd1, 12'h2A5});
        exp_res.push_back({3'd2, 12'h5C3});
        n_convst = 0; busy_cnt = 0; rv0 = rv_cnt; ov0 = ov_cnt;
        pulse_start();
        repeat (150) tick();
        bus.ch_mask = 8'hFF;
        bus.uni     = 1'b1;
        pulse_start();
        check("t4_overrun_pulse", bus.overrun, 1);
        tick();
        check("t4_overrun_one_cycle", bus.overrun, 0);
        wait_done(1500);
        check("t4_overrun_count", ov_cnt - ov0, 1);
        check("t4_frames", n_convst, 3);
        check("t4_busy_width", busy_cnt, 388);
        check("t4_results", rv_cnt - rv0, 2);
        check("t4_res_queue", exp_res.size(), 0);
        check("t4_sdi_queue", exp_sdi.size(), 0);

        // Reset at the 6th SCK pulse of a scan, then a fresh scan.
        val[0] = 12'hABC;
        bus.ch_mask = 8'h01;
        bus.uni     = 1'b1;
        exp_sdi.push_back({6'b100010, 6'b0});
        exp_sdi.push_back({6'b100010, 6'b0});
        exp_res.push_back({3'd0, 12'hABC});
        rv0 = rv_cnt; sd0 = sd_cnt;
        pulse_start();
        for (int i = 0; i < 300 && nrise != 6; i++) tick();
        check("t5_at_pulse6", nrise, 6);
        reset_reset = 1'b1;
        #1;
        check("t5_reset_outputs", outs, 0);
        repeat (3) tick();
        reset_reset = 1'b0;
        exp_sdi.delete();
        exp_res.delete();
        repeat (2) tick();
        check("t5_no_result", rv_cnt - rv0, 0);
        check("t5_no_done", sd_cnt - sd0, 0);
        exp_sdi.push_back({6'b100010, 6'b0});
        exp_sdi.push_back({6'b100010, 6'b0});
        exp_res.push_back({3'd0, 12'hABC});
        n_convst = 0; nfull = 0; busy_cnt = 0; rv0 = rv_cnt;
        pulse_start();
        wait_done(1000);
        check("t5_frames", n_convst, 2);
        check("t5_full_frames", nfull, 2);
        check("t5_busy_width", busy_cnt, 259);
        check("t5_results", rv_cnt - rv0, 1);
        check("t5_res_queue", exp_res.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
